// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; same-cycle one-hot grant, priority rotates past each winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic               allow_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [PW-1:0]      ptr, off, gidx, nxt;
    logic [NUM_REQ-1:0] rot;
    logic [PW:0]        sum;
    logic               found;
    // rot[k] is the request at index (ptr + k) mod NUM_REQ, so the lowest set bit wins
    always_comb begin
        rot = NUM_REQ'({req_i, req_i} >> ptr);
        found = 1'b0;
        off = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (!found && rot[k]) begin
                found = 1'b1;
                off = PW'(k);
            end
        sum = {1'b0, ptr} + {1'b0, off};
        gidx = sum >= (PW+1)'(NUM_REQ) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
        nxt = gidx == PW'(NUM_REQ - 1) ? '0 : gidx + PW'(1);
        gnt_o = found && allow_i && arst_ni ? NUM_REQ'(1) << gidx : '0;
    end
    always_ff @(posedge clk_i)
        if (!arst_ni) ptr <= '0;
        else if (|gnt_o) ptr <= nxt;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and randomized checks of rr_arbiter against a priority-search model.
module tb_rr_arbiter;
    localparam int N = 4;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         allow = 1'b1;
    logic [N-1:0] req = '1;
    logic [N-1:0] gnt;
    int n_cmp = 0;
    int n_err = 0;
    int mptr = 0;
    int grants [N];
    int wait_cnt [N];

    rr_arbiter #(.NUM_REQ(N)) dut (
        .clk_i(clk), .arst_ni(rst_n), .allow_i(allow), .req_i(req), .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner by walking indices from mptr upward with wrap; -1 when nothing is granted
    function automatic int pick(input logic [N-1:0] r, input logic a, input logic rn);
        if (!a || !rn) return -1;
        for (int k = 0; k < N; k++)
            if (r[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Drive one cycle, compare mid-cycle against the model (and an optional constant), then advance the model
    task automatic cyc(input string tag, input logic [N-1:0] r, input logic a, input logic rn,
                       input logic [N-1:0] exp, input bit use_exp);
        int g;
        req = r; allow = a; rst_n = rn;
        @(negedge clk);
        g = pick(r, a, rn);
        check({tag, "_model"}, 32'(gnt), 32'(onehot(g)));
        if (use_exp) check(tag, 32'(gnt), 32'(exp));
        @(posedge clk);
        if (!rn) mptr = 0;
        else if (g >= 0) mptr = (g + 1) % N;
        #1;
    endtask

    initial begin
        logic [N-1:0] r;
        logic a;
        int g;
        logic [3:0] rot_seq [8];
        rot_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        repeat (2) cyc("reset", 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 8; i++) cyc("rotate", 4'b1111, 1'b1, 1'b1, rot_seq[i], 1'b1);
        cyc("rst2", 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) cyc("sparse", 4'b1010, 1'b1, 1'b1, i % 2 ? 4'b1000 : 4'b0010, 1'b1);
        cyc("skip", 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1);
        cyc("pre_outage", 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1);
        repeat (3) cyc("outage", 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1);
        cyc("resume", 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1);
        cyc("midrst", 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1);
        cyc("after_rst", 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1);
        cyc("none", 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1);
        for (int i = 0; i < N; i++) begin grants[i] = 0; wait_cnt[i] = 0; end
        for (int c = 0; c < 8000 && $time < 1ms; c++) begin
            r = N'($urandom);
            a = $urandom_range(99) >= 3;
            req = r; allow = a; rst_n = 1'b1;
            @(negedge clk);
            g = pick(r, a, 1'b1);
            check("rand_model", 32'(gnt), 32'(onehot(g)));
            check("rand_onehot", 32'($onehot0(gnt)), 32'd1);
            check("rand_subset", 32'(gnt & ~r), 32'd0);
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) grants[i]++;
                if (!r[i] || gnt[i]) wait_cnt[i] = 0;
                else if (a) wait_cnt[i]++;
            end
            for (int i = 0; i < N; i++) check("rand_starve", 32'(wait_cnt[i] >= N), 32'd0);
            @(posedge clk);
            if (g >= 0) mptr = (g + 1) % N;
            #1;
        end
        check("timeout", 32'($time < 1ms), 32'd1);
        for (int i = 0; i < N; i++) check("grant_count", 32'(grants[i] >= 1000), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
